// File: rtl/button_led_pkg.sv
// Shared mode encoding, default timing parameters and the mode transition
// rule for the push-button LED controller.
package button_led_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 4;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 16;
  localparam int DEFAULT_BLINK_HALF_PERIOD = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_t;

  // Where a classified press takes the LED mode; unknown encodings fall back to OFF.
  function automatic mode_t mode_after_press(input mode_t cur, input logic is_long);
    mode_t nxt;
    case (cur)
      MODE_OFF:   nxt = is_long ? MODE_BLINK : MODE_ON;
      MODE_ON:    nxt = is_long ? MODE_BLINK : MODE_OFF;
      default:    nxt = MODE_OFF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer: the debounced level
// only follows the synchronised input after DEBOUNCE_CYCLES consecutive disagreements.
module button_debounce
  import button_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  // Any cycle of agreement restarts the run, so short glitches never flip btn_db.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db <= 1'b0;
      cnt    <= '0;
    end else if (s2 != btn_db) begin
      if (cnt == CNT_LAST) begin
        btn_db <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/button_led_controller.sv
// Push-button LED sequencer: debounced button presses are classified as short
// or long and step an OFF / ON / BLINK mode machine that drives the LED.
module button_led_controller
  import button_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int BLINK_HALF_PERIOD = DEFAULT_BLINK_HALF_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  output logic       y,
  output logic [1:0] mode,
  output logic       short_press,
  output logic       long_press
);

  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

  logic          btn_db;
  logic          db_q;
  logic [HW-1:0] hold;
  logic          long_fired;

  mode_t         state_q;
  mode_t         state_d;
  logic          y_q;
  logic          y_d;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_d;
  logic          pulse;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .btn_db(btn_db)
  );

  // Hold count is zero whenever the button is up, so every press starts fresh;
  // once a long press has fired, the release is swallowed instead of counting as short.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q        <= 1'b0;
      hold        <= '0;
      long_fired  <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      db_q        <= btn_db;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      if (btn_db) begin
        if (hold != HOLD_MAX) begin
          hold <= hold + HW'(1);
        end
        if (hold == HOLD_LAST) begin
          long_press <= 1'b1;
          long_fired <= 1'b1;
        end
      end else begin
        hold <= '0;
        if (db_q) begin
          short_press <= ~long_fired;
          long_fired  <= 1'b0;
        end
      end
    end
  end

  assign pulse = short_press | long_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MODE_OFF;
      y_q       <= 1'b0;
      blink_cnt <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      blink_cnt <= blink_d;
    end
  end

  // LED level follows the next mode so y and mode change on the same edge.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    blink_d = blink_cnt;

    case (state_q)
      MODE_OFF, MODE_ON, MODE_BLINK: begin
        if (pulse) begin
          state_d = mode_after_press(state_q, long_press);
        end
      end
      default: state_d = MODE_OFF;
    endcase

    case (state_d)
      MODE_ON: begin
        y_d     = 1'b1;
        blink_d = '0;
      end
      MODE_BLINK: begin
        if (state_q != MODE_BLINK) begin
          y_d     = 1'b1;
          blink_d = '0;
        end else if (blink_cnt == BLINK_LAST) begin
          y_d     = ~y_q;
          blink_d = '0;
        end else begin
          blink_d = blink_cnt + BW'(1);
        end
      end
      default: begin
        y_d     = 1'b0;
        blink_d = '0;
      end
    endcase
  end

  assign y    = y_q;
  assign mode = state_q;

endmodule

// File: tb/tb_button_led_controller.sv
// Self-checking bench for button_led_controller: a cycle-level behavioural model
// is compared every cycle, plus hand-computed latency and blink-pattern checks.
module tb_button_led_controller;

  localparam int DC = 4;
  localparam int LP = 16;
  localparam int HP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic       y;
  logic [1:0] mode;
  logic       short_press;
  logic       long_press;

  button_led_controller #(
    .DEBOUNCE_CYCLES  (DC),
    .LONG_PRESS_CYCLES(LP),
    .BLINK_HALF_PERIOD(HP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .y          (y),
    .mode       (mode),
    .short_press(short_press),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int mark       = 0;

  int short_cnt  = 0;
  int long_cnt   = 0;
  int last_short = -1000;
  int last_long  = -1000;
  logic ylog [0:4095];

  // Model state: raw samples, debounced level, run length of disagreement,
  // press length in cycles, mode, age inside BLINK, and expected outputs.
  int m_s1 = 0, m_s2 = 0, m_db = 0, m_run = 0, m_len = 0;
  int m_mode = 0, m_age = 0, m_y = 0, m_short = 0, m_long = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Holds button at level b for exactly n sampling edges; mark = cycle before the first.
  task automatic applyStimulus(input logic b, input int n);
    @(negedge clk);
    button = b;
    mark   = cyc;
    repeat (n) @(posedge clk);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_len = 0;
      m_mode = 0; m_age = 0; m_y = 0; m_short = 0; m_long = 0;
    end else begin
      if (m_short != 0 || m_long != 0) begin
        case (m_mode)
          0:       m_mode = (m_long != 0) ? 2 : 1;
          1:       m_mode = (m_long != 0) ? 2 : 0;
          default: m_mode = 0;
        endcase
        m_age = 0;
      end else if (m_mode == 2) begin
        m_age++;
      end
      if (m_mode == 1)      m_y = 1;
      else if (m_mode == 2) m_y = (((m_age / HP) % 2) == 0) ? 1 : 0;
      else                  m_y = 0;

      m_short = 0;
      m_long  = 0;
      if (m_db != 0) begin
        if (m_len < LP) begin
          m_len++;
          if (m_len == LP) m_long = 1;
        end
      end else begin
        if (m_len > 0 && m_len < LP) m_short = 1;
        m_len = 0;
      end

      if (m_s2 != m_db) begin
        m_run++;
        if (m_run == DC) begin
          m_db  = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = (button === 1'b1) ? 1 : 0;
    end
  end

  always @(posedge clk) begin
    #1;
    checkOutput("y",           32'(y),           32'(m_y));
    checkOutput("mode",        32'(mode),        32'(m_mode));
    checkOutput("short_press", 32'(short_press), 32'(m_short));
    checkOutput("long_press",  32'(long_press),  32'(m_long));
    if (cyc < 4096) ylog[cyc] = y;
    if (short_press === 1'b1) begin
      short_cnt++;
      last_short = cyc;
    end
    if (long_press === 1'b1) begin
      long_cnt++;
      last_long = cyc;
    end
  end

  initial begin
    int rise;
    $display("[TB] start");

    // Reset held for three cycles
    rst = 1'b1;
    button = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_y",     32'(y),           32'd0);
    checkOutput("reset_mode",  32'(mode),        32'd0);
    checkOutput("reset_short", 32'(short_press), 32'd0);
    checkOutput("reset_long",  32'(long_press),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Three-cycle glitch is rejected
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 12);
    checkOutput("glitch_short_cnt", 32'(short_cnt), 32'd0);
    checkOutput("glitch_long_cnt",  32'(long_cnt),  32'd0);
    checkOutput("glitch_mode",      32'(mode),      32'd0);

    // Short press: OFF -> ON, pulse 7 edges after raw release
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);
    checkOutput("short1_delay", 32'(last_short - mark), 32'd7);
    checkOutput("short1_cnt",   32'(short_cnt),         32'd1);
    checkOutput("short1_mode",  32'(mode),              32'd1);
    checkOutput("short1_y",     32'(y),                 32'd1);

    // Second short press: ON -> OFF
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);
    checkOutput("short2_delay", 32'(last_short - mark), 32'd7);
    checkOutput("short2_mode",  32'(mode),              32'd0);
    checkOutput("short2_y",     32'(y),                 32'd0);

    // Long press: 6 edges to debounce + 16 held -> pulse 22 edges after raw rise
    applyStimulus(1'b1, 40);
    rise = mark;
    checkOutput("long_delay", 32'(last_long - rise), 32'd22);
    checkOutput("long_cnt",   32'(long_cnt),         32'd1);
    checkOutput("long_mode",  32'(mode),             32'd2);
    checkOutput("blink_y_23", 32'(ylog[rise + 23]),  32'd1);
    checkOutput("blink_y_30", 32'(ylog[rise + 30]),  32'd1);
    checkOutput("blink_y_31", 32'(ylog[rise + 31]),  32'd0);
    checkOutput("blink_y_38", 32'(ylog[rise + 38]),  32'd0);
    checkOutput("blink_y_39", 32'(ylog[rise + 39]),  32'd1);
    applyStimulus(1'b0, 15);
    checkOutput("long_release_short_cnt", 32'(short_cnt), 32'd2);
    checkOutput("long_release_mode",      32'(mode),      32'd2);

    // Short press leaves BLINK
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);
    checkOutput("exit_blink_delay", 32'(last_short - mark), 32'd7);
    checkOutput("exit_blink_mode",  32'(mode),              32'd0);
    checkOutput("exit_blink_y",     32'(y),                 32'd0);

    // Into ON, then reset while the button is held
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);
    checkOutput("pre_reset_mode", 32'(mode), 32'd1);
    applyStimulus(1'b1, 15);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_mode", 32'(mode), 32'd0);
    checkOutput("midreset_y",    32'(y),    32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 15);
    checkOutput("post_reset_delay",     32'(last_short - mark), 32'd7);
    checkOutput("post_reset_short_cnt", 32'(short_cnt),         32'd5);
    checkOutput("post_reset_long_cnt",  32'(long_cnt),          32'd1);
    checkOutput("post_reset_mode",      32'(mode),              32'd1);
    checkOutput("post_reset_y",         32'(y),                 32'd1);

    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
